commit_tracker_mc_mpu: RTL and testbench

//  Multi-channel, in-order commit tracker for the MPU; parametrised successor of the single-port commit unit.

---
 rtl/pkg_mpu.sv | 20 ++
 rtl/commit_clear_mpu.sv | 43 ++++
 rtl/commit_tracker_mc_mpu.sv | 146 ++++++++++++++
 tb/tb_commit_tracker_mc_mpu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_mpu.sv
// Shared configuration and types for the MPU commit tracker.
//   NUM_COMMIT_CH : default number of TPU commit channels
//   DEPTH_COMMIT  : default number of outstanding-thread entries
//   WIDTH_ISSUE   : issue-number width for the default depth
package pkg_mpu;

    localparam int unsigned NUM_COMMIT_CH = 4;
    localparam int unsigned DEPTH_COMMIT  = 16;
    localparam int unsigned WIDTH_ISSUE   = $clog2(DEPTH_COMMIT);

    typedef logic [NUM_COMMIT_CH-1:0] commit_mask_t;
    typedef logic [WIDTH_ISSUE-1:0]   issue_no_t;

    // One tracker slot: occupied flag plus channels still owing a commit.
    typedef struct packed {
        logic         valid;
        commit_mask_t pending;
    } commit_entry_t;

endpackage

// File: rtl/commit_clear_mpu.sv
// Combinational commit decoder: maps NUM_CH commit requests onto per-entry
// pending-bit clear masks and flags any illegal commit.
//   i_req_commit   : per-channel commit valid
//   i_commit_no    : per-channel issue number, channel c at [c*WI +: WI]
//   i_valid        : registered entry valid bits
//   i_pending      : registered pending bits, entry e at [e*NUM_CH +: NUM_CH]
//   o_clr_c        : pending bits to clear, same layout as i_pending
//   o_err_c        : at least one commit targeted an invalid entry or a clear bit
module commit_clear_mpu
    import pkg_mpu::*;
#(
    parameter  int unsigned NUM_CH = NUM_COMMIT_CH,
    parameter  int unsigned DEPTH  = DEPTH_COMMIT,
    localparam int unsigned WI     = $clog2(DEPTH)
) (
    input  logic [NUM_CH-1:0]       i_req_commit,
    input  logic [NUM_CH*WI-1:0]    i_commit_no,
    input  logic [DEPTH-1:0]        i_valid,
    input  logic [DEPTH*NUM_CH-1:0] i_pending,
    output logic [DEPTH*NUM_CH-1:0] o_clr_c,
    output logic                    o_err_c
);

    logic [WI-1:0] idx;

    // Each channel owns a distinct bit column, so channels never collide.
    always_comb begin
        o_clr_c = '0;
        o_err_c = 1'b0;
        idx     = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            idx = i_commit_no[c*int'(WI) +: WI];
            if (i_req_commit[c]) begin
                if (i_valid[idx] && i_pending[int'(idx)*int'(NUM_CH) + c]) begin
                    o_clr_c[int'(idx)*int'(NUM_CH) + c] = 1'b1;
                end else begin
                    o_err_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/commit_tracker_mc_mpu.sv
// Multi-channel in-order commit tracker. Hands out issue numbers at the tail,
// collects out-of-order per-channel commits, retires at most one entry per
// cycle from the head in issue order.
//   clock, reset     : rising-edge clock, async active-low reset
//   I_Flush          : drop every outstanding entry (priority over all else)
//   I_Req_Issue/I_En_Mask, O_Ack_Issue/O_Issue_No : issue handshake (comb)
//   I_Req_Commit/I_CommitNo : per-channel commits
//   O_Req_Commit/O_Commit_No : registered retire pulse and retired number
//   O_Count/O_Full/O_Empty   : registered occupancy
//   O_Err            : registered pulse on illegal commit
module commit_tracker_mc_mpu
    import pkg_mpu::*;
#(
    parameter  int unsigned NUM_CH      = NUM_COMMIT_CH,
    parameter  int unsigned DEPTH       = DEPTH_COMMIT,
    localparam int unsigned WIDTH_ISSUE = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          I_Flush,
    input  logic                          I_Req_Issue,
    input  logic [NUM_CH-1:0]             I_En_Mask,
    output logic                          O_Ack_Issue,
    output logic [WIDTH_ISSUE-1:0]        O_Issue_No,
    input  logic [NUM_CH-1:0]             I_Req_Commit,
    input  logic [NUM_CH*WIDTH_ISSUE-1:0] I_CommitNo,
    output logic                          O_Req_Commit,
    output logic [WIDTH_ISSUE-1:0]        O_Commit_No,
    output logic [WIDTH_ISSUE:0]          O_Count,
    output logic                          O_Full,
    output logic                          O_Empty,
    output logic                          O_Err
);

    localparam int unsigned WI = WIDTH_ISSUE;
    localparam int unsigned CW = WIDTH_ISSUE + 1;

    logic [WI-1:0]           head_q, head_d;
    logic [WI-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH*NUM_CH-1:0] pend_q, pend_d;
    logic [WI-1:0]           commit_no_q, commit_no_d;
    logic                    req_commit_q, req_commit_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    err_q, err_d;

    logic [DEPTH*NUM_CH-1:0] clr_c;
    logic                    err_c;
    logic                    ack_c;
    logic                    retire_c;

    commit_clear_mpu #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) u_clear (
        .i_req_commit (I_Req_Commit),
        .i_commit_no  (I_CommitNo),
        .i_valid      (valid_q),
        .i_pending    (pend_q),
        .o_clr_c      (clr_c),
        .o_err_c      (err_c)
    );

    // Issue is gated by the registered full flag so a same-cycle retire does not
    // open the slot early.
    assign ack_c    = I_Req_Issue & ~full_q & ~I_Flush;
    // Retire decision uses registered pending bits only; same-cycle commits wait.
    assign retire_c = valid_q[head_q] &&
                      (pend_q[int'(head_q)*int'(NUM_CH) +: NUM_CH] == '0);

    // Next-state for entries, pointers, occupancy and output registers.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        pend_d       = pend_q & ~clr_c;
        commit_no_d  = commit_no_q;
        req_commit_d = retire_c;
        err_d        = err_c;
        count_d      = count_q + CW'(ack_c) - CW'(retire_c);

        if (retire_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + WI'(1);
            commit_no_d     = head_q;
        end

        if (ack_c) begin
            valid_d[tail_q]                                 = 1'b1;
            pend_d[int'(tail_q)*int'(NUM_CH) +: NUM_CH]     = I_En_Mask;
            tail_d                                          = tail_q + WI'(1);
        end

        if (I_Flush) begin
            head_d       = '0;
            tail_d       = '0;
            valid_d      = '0;
            pend_d       = '0;
            count_d      = '0;
            req_commit_d = 1'b0;
            err_d        = 1'b0;
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            pend_q       <= '0;
            commit_no_q  <= '0;
            req_commit_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            commit_no_q  <= commit_no_d;
            req_commit_q <= req_commit_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
        end
    end

    assign O_Ack_Issue  = ack_c;
    assign O_Issue_No   = tail_q;
    assign O_Req_Commit = req_commit_q;
    assign O_Commit_No  = commit_no_q;
    assign O_Count      = count_q;
    assign O_Full       = full_q;
    assign O_Empty      = empty_q;
    assign O_Err        = err_q;

endmodule

// File: tb/tb_commit_tracker_mc_mpu.sv
// Directed bench for commit_tracker_mc_mpu (NUM_CH=4, DEPTH=16).
module tb_commit_tracker_mc_mpu;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_issue;
    logic [3:0]  en_mask;
    logic        ack_issue;
    logic [3:0]  issue_no;
    logic [3:0]  req_commit;
    logic [15:0] commit_no_in;
    logic        ret_req;
    logic [3:0]  ret_no;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    commit_tracker_mc_mpu dut (
        .clock        (clock),
        .reset        (reset),
        .I_Flush      (flush),
        .I_Req_Issue  (req_issue),
        .I_En_Mask    (en_mask),
        .O_Ack_Issue  (ack_issue),
        .O_Issue_No   (issue_no),
        .I_Req_Commit (req_commit),
        .I_CommitNo   (commit_no_in),
        .O_Req_Commit (ret_req),
        .O_Commit_No  (ret_no),
        .O_Count      (count),
        .O_Full       (full),
        .O_Empty      (empty),
        .O_Err        (err)
    );

    typedef struct {
        logic        fl;
        logic        ri;
        logic [3:0]  mask;
        logic [3:0]  rc;
        logic [15:0] cn;
        logic        ack;
        logic [3:0]  ino;
        logic        req;
        logic [3:0]  cno;
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
        logic        err;
    } vec_t;

    localparam int NV = 33;
    vec_t vt [NV];

    function automatic vec_t mk(input logic fl, input logic ri, input logic [3:0] mask,
                                input logic [3:0] rc, input logic [15:0] cn,
                                input logic ack, input logic [3:0] ino, input logic req,
                                input logic [3:0] cno, input logic [4:0] cnt,
                                input logic fu, input logic em, input logic er);
        vec_t v;
        v.fl = fl; v.ri = ri; v.mask = mask; v.rc = rc; v.cn = cn;
        v.ack = ack; v.ino = ino; v.req = req; v.cno = cno; v.cnt = cnt;
        v.full = fu; v.empty = em; v.err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic ri, input logic [3:0] mask,
                         input logic [3:0] rc, input logic [15:0] cn);
        flush = fl; req_issue = ri; en_mask = mask; req_commit = rc; commit_no_in = cn;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 16'h0);
    endtask

    // Move to the next cycle: just after the rising edge.
    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Cycle-by-cycle expectations; outputs sampled at the falling edge.
        //            fl ri mask  rc    cn        ack ino req cno cnt fu em er
        vt[0]  = mk(0, 1, 4'h3, 4'h0, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0);
        vt[1]  = mk(0, 1, 4'h3, 4'h0, 16'h0000, 1, 1, 0, 0, 1, 0, 0, 0);
        vt[2]  = mk(0, 1, 4'h3, 4'h0, 16'h0000, 1, 2, 0, 0, 2, 0, 0, 0);
        vt[3]  = mk(0, 0, 4'h0, 4'h3, 16'h0000, 0, 3, 0, 0, 3, 0, 0, 0);
        vt[4]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 0, 0, 3, 0, 0, 0);
        vt[5]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 1, 0, 2, 0, 0, 0);
        vt[6]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 0, 0, 2, 0, 0, 0);
        // Younger #2 completes before #1.
        vt[7]  = mk(0, 0, 4'h0, 4'h3, 16'h0022, 0, 3, 0, 0, 2, 0, 0, 0);
        vt[8]  = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 0, 0, 2, 0, 0, 0);
        vt[9]  = mk(0, 0, 4'h0, 4'h3, 16'h0011, 0, 3, 0, 0, 2, 0, 0, 0);
        vt[10] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 0, 0, 2, 0, 0, 0);
        vt[11] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 1, 1, 1, 0, 0, 0);
        vt[12] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 1, 2, 0, 0, 1, 0);
        vt[13] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 3, 0, 2, 0, 0, 1, 0);
        // Four channels close entry #3 together.
        vt[14] = mk(0, 1, 4'hF, 4'h0, 16'h0000, 1, 3, 0, 2, 0, 0, 1, 0);
        vt[15] = mk(0, 0, 4'h0, 4'hF, 16'h3333, 0, 4, 0, 2, 1, 0, 0, 0);
        vt[16] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 4, 0, 2, 1, 0, 0, 0);
        vt[17] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 4, 1, 3, 0, 0, 1, 0);
        // Commit to invalid #5.
        vt[18] = mk(0, 0, 4'h0, 4'h4, 16'h0500, 0, 4, 0, 3, 0, 0, 1, 0);
        vt[19] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 4, 0, 3, 0, 0, 1, 1);
        vt[20] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 4, 0, 3, 0, 0, 1, 0);
        // Duplicate and out-of-mask commits to #4.
        vt[21] = mk(0, 1, 4'h3, 4'h0, 16'h0000, 1, 4, 0, 3, 0, 0, 1, 0);
        vt[22] = mk(0, 0, 4'h0, 4'h1, 16'h0004, 0, 5, 0, 3, 1, 0, 0, 0);
        vt[23] = mk(0, 0, 4'h0, 4'h1, 16'h0004, 0, 5, 0, 3, 1, 0, 0, 0);
        vt[24] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 5, 0, 3, 1, 0, 0, 1);
        vt[25] = mk(0, 0, 4'h0, 4'h8, 16'h4000, 0, 5, 0, 3, 1, 0, 0, 0);
        vt[26] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 5, 0, 3, 1, 0, 0, 1);
        vt[27] = mk(0, 0, 4'h0, 4'h2, 16'h0040, 0, 5, 0, 3, 1, 0, 0, 0);
        vt[28] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 5, 0, 3, 1, 0, 0, 0);
        vt[29] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 5, 1, 4, 0, 0, 1, 0);
        // Zero-mask issue retires two cycles later.
        vt[30] = mk(0, 1, 4'h0, 4'h0, 16'h0000, 1, 5, 0, 4, 0, 0, 1, 0);
        vt[31] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 6, 0, 4, 1, 0, 0, 0);
        vt[32] = mk(0, 0, 4'h0, 4'h0, 16'h0000, 0, 6, 1, 5, 0, 0, 1, 0);

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req",   32'(ret_req), 0);
        chk("rst_no",    32'(ret_no),  0);
        chk("rst_count", 32'(count),   0);
        chk("rst_full",  32'(full),    0);
        chk("rst_empty", 32'(empty),   1);
        chk("rst_err",   32'(err),     0);
        next_cyc();
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].fl, vt[i].ri, vt[i].mask, vt[i].rc, vt[i].cn);
            @(negedge clock);
            chk($sformatf("v%0d_ack", i),   32'(ack_issue), 32'(vt[i].ack));
            chk($sformatf("v%0d_ino", i),   32'(issue_no),  32'(vt[i].ino));
            chk($sformatf("v%0d_req", i),   32'(ret_req),   32'(vt[i].req));
            chk($sformatf("v%0d_cno", i),   32'(ret_no),    32'(vt[i].cno));
            chk($sformatf("v%0d_cnt", i),   32'(count),     32'(vt[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(full),      32'(vt[i].full));
            chk($sformatf("v%0d_empty", i), 32'(empty),     32'(vt[i].empty));
            chk($sformatf("v%0d_err", i),   32'(err),       32'(vt[i].err));
            next_cyc();
        end

        // Flush with 5 outstanding; #6 becomes retirable in the flush cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'h1, 4'h0, 16'h0);
            @(negedge clock);
            chk("fl_fill_ack", 32'(ack_issue), 1);
            chk("fl_fill_ino", 32'(issue_no),  32'(6 + i));
            next_cyc();
        end
        drive(1'b0, 1'b0, 4'h0, 4'h1, 16'h0006);
        @(negedge clock);
        chk("fl_pre_cnt", 32'(count), 5);
        next_cyc();
        drive(1'b1, 1'b1, 4'h1, 4'h3, 16'h00F7);
        @(negedge clock);
        chk("fl_ack", 32'(ack_issue), 0);
        chk("fl_cnt", 32'(count), 5);
        next_cyc();
        idle();
        @(negedge clock);
        chk("fl_post_cnt",   32'(count),    0);
        chk("fl_post_empty", 32'(empty),    1);
        chk("fl_post_full",  32'(full),     0);
        chk("fl_post_req",   32'(ret_req),  0);
        chk("fl_post_err",   32'(err),      0);
        chk("fl_post_ino",   32'(issue_no), 0);
        next_cyc();
        @(negedge clock);
        chk("fl_post2_req", 32'(ret_req), 0);
        chk("fl_post2_err", 32'(err),     0);
        next_cyc();

        // Fill all 16 entries, reject the 17th, then wrap after one retire.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'h1, 4'h0, 16'h0);
            @(negedge clock);
            chk("fill_ack", 32'(ack_issue), 1);
            chk("fill_ino", 32'(issue_no),  32'(i));
            next_cyc();
        end
        drive(1'b0, 1'b1, 4'h1, 4'h0, 16'h0);
        @(negedge clock);
        chk("full_ack",   32'(ack_issue), 0);
        chk("full_cnt",   32'(count),     16);
        chk("full_full",  32'(full),      1);
        chk("full_empty", 32'(empty),     0);
        next_cyc();
        idle();
        @(negedge clock);
        chk("full_hold_cnt", 32'(count), 16);
        chk("full_hold_ino", 32'(issue_no), 0);
        next_cyc();
        drive(1'b0, 1'b0, 4'h0, 4'h1, 16'h0000);
        @(negedge clock);
        chk("wrap_c_cnt", 32'(count), 16);
        next_cyc();
        idle();
        @(negedge clock);
        chk("wrap_c1_req", 32'(ret_req), 0);
        next_cyc();
        drive(1'b0, 1'b1, 4'h1, 4'h0, 16'h0);
        @(negedge clock);
        chk("wrap_req",  32'(ret_req),   1);
        chk("wrap_no",   32'(ret_no),    0);
        chk("wrap_cnt",  32'(count),     15);
        chk("wrap_full", 32'(full),      0);
        chk("wrap_ack",  32'(ack_issue), 1);
        chk("wrap_ino",  32'(issue_no),  0);
        next_cyc();
        idle();
        @(negedge clock);
        chk("wrap_refull_cnt",  32'(count), 16);
        chk("wrap_refull_full", 32'(full),  1);
        chk("wrap_refull_req",  32'(ret_req), 0);
        next_cyc();

        // Asynchronous reset mid-run with a commit in flight.
        drive(1'b0, 1'b0, 4'h0, 4'h1, 16'h0001);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cnt",   32'(count),    0);
        chk("arst_empty", 32'(empty),    1);
        chk("arst_full",  32'(full),     0);
        chk("arst_req",   32'(ret_req),  0);
        chk("arst_err",   32'(err),      0);
        chk("arst_no",    32'(ret_no),   0);
        chk("arst_ino",   32'(issue_no), 0);
        idle();
        next_cyc();
        reset = 1'b1;
        @(negedge clock);
        chk("arst_rel_cnt", 32'(count),   0);
        chk("arst_rel_req", 32'(ret_req), 0);
        next_cyc();
        drive(1'b0, 1'b1, 4'h1, 4'h0, 16'h0);
        @(negedge clock);
        chk("arst_iss_ack", 32'(ack_issue), 1);
        chk("arst_iss_ino", 32'(issue_no),  0);
        next_cyc();
        idle();
        @(negedge clock);
        chk("arst_iss_cnt", 32'(count), 1);
        chk("arst_iss_ino2", 32'(issue_no), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
